// File: rtl/cb_zigzag_serializer.sv
// cb_zigzag_serializer
//   Takes one 8x8 block of signed 11-bit DCT coefficients (704 bits,
//   row-major, coefficient k = (r-1)*8+(c-1) at bits [11k+10:11k]) and
//   streams the coefficients out one per transfer in JPEG zigzag order.
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   block_valid/_in    : block offered by the upstream DCT
//   block_ready        : registered; block accepted when valid && ready
//   coef_out/_index    : coefficient and its zigzag position 0..63
//   coef_valid/_ready  : downstream handshake
//   coef_last          : marks zigzag position 63
//   drop               : sticky, a block was offered while block_ready was low
//
// Configuration
//   CB_ZZ_DOUBLE_BUF_EN : when defined, a second block buffer lets the next
//                         block queue during SEND and follow without a gap.
module cb_zigzag_serializer (
  input  logic         clk,
  input  logic         rst,
  input  logic         block_valid,
  input  logic [703:0] block_in,
  output logic         block_ready,
  output logic [10:0]  coef_out,
  output logic         coef_valid,
  input  logic         coef_ready,
  output logic [5:0]   coef_index,
  output logic         coef_last,
  output logic         drop
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

  // Zigzag position -> row-major coefficient number.
  localparam logic [5:0] ZZ_TABLE [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Raw 11-bit field of coefficient k; copied bit-exact, never extended.
  function automatic logic [10:0] coef_at(input logic [703:0] blk, input logic [5:0] k);
    logic [9:0] base;
    base = {4'd0, k} * 10'd11;
    return blk[base +: 11];
  endfunction

  state_e        state_q, state_d;
  logic [703:0]  buf0_q, buf0_d;
  logic [10:0]   coef_out_q, coef_out_d;
  logic [5:0]    coef_index_q, coef_index_d;
  logic          coef_valid_q, coef_valid_d;
  logic          coef_last_q, coef_last_d;
  logic          block_ready_q, block_ready_d;
  logic          drop_q, drop_d;
`ifdef CB_ZZ_DOUBLE_BUF_EN
  logic [703:0]  buf1_q, buf1_d;
  logic          buf1_full_q, buf1_full_d;
`endif

  logic          accept_s;
  logic          xfer_s;
  logic          load_s;
  logic          go_idle_s;
  logic [703:0]  load_blk_s;

  // Next-state, buffer and output computation.
  always_comb begin
    accept_s     = block_valid && block_ready_q;
    xfer_s       = coef_valid_q && coef_ready;
    load_s       = 1'b0;
    go_idle_s    = 1'b0;
    load_blk_s   = block_in;
    state_d      = state_q;
    buf0_d       = buf0_q;
    coef_out_d   = coef_out_q;
    coef_index_d = coef_index_q;
    coef_valid_d = coef_valid_q;
    coef_last_d  = coef_last_q;
    drop_d       = drop_q | (block_valid & ~block_ready_q);
`ifdef CB_ZZ_DOUBLE_BUF_EN
    buf1_d       = buf1_q;
    buf1_full_d  = buf1_full_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          load_s     = 1'b1;
          load_blk_s = block_in;
        end else begin
          load_s     = 1'b0;
        end
      end
      SEND: begin
        if (xfer_s && coef_last_q) begin
`ifdef CB_ZZ_DOUBLE_BUF_EN
          // Start the queued block (or one arriving right now) with no gap.
          if (buf1_full_q) begin
            load_s      = 1'b1;
            load_blk_s  = buf1_q;
            buf1_full_d = accept_s;
            buf1_d      = accept_s ? block_in : buf1_q;
          end else if (accept_s) begin
            load_s      = 1'b1;
            load_blk_s  = block_in;
          end else begin
            go_idle_s   = 1'b1;
          end
`else
          go_idle_s = 1'b1;
`endif
        end else begin
          if (xfer_s) begin
            coef_index_d = coef_index_q + 6'd1;
            coef_out_d   = coef_at(buf0_q, ZZ_TABLE[coef_index_q + 6'd1]);
            coef_last_d  = (coef_index_q == 6'd62);
          end else begin
            coef_index_d = coef_index_q;
          end
`ifdef CB_ZZ_DOUBLE_BUF_EN
          // block_ready is only high here while the second buffer is empty.
          if (accept_s) begin
            buf1_d      = block_in;
            buf1_full_d = 1'b1;
          end else begin
            buf1_full_d = buf1_full_q;
          end
`endif
        end
      end
      default: begin
        go_idle_s = 1'b1;
      end
    endcase

    if (load_s) begin
      state_d      = SEND;
      buf0_d       = load_blk_s;
      coef_out_d   = load_blk_s[10:0];
      coef_index_d = 6'd0;
      coef_valid_d = 1'b1;
      coef_last_d  = 1'b0;
    end else if (go_idle_s) begin
      state_d      = IDLE;
      coef_out_d   = 11'd0;
      coef_index_d = 6'd0;
      coef_valid_d = 1'b0;
      coef_last_d  = 1'b0;
    end else begin
      state_d      = state_q;
    end

`ifdef CB_ZZ_DOUBLE_BUF_EN
    block_ready_d = !((state_d == SEND) && buf1_full_d);
`else
    block_ready_d = (state_d == IDLE);
`endif
  end

  // State, buffer and registered-output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      buf0_q        <= {704{1'b0}};
      coef_out_q    <= 11'd0;
      coef_index_q  <= 6'd0;
      coef_valid_q  <= 1'b0;
      coef_last_q   <= 1'b0;
      block_ready_q <= 1'b0;
      drop_q        <= 1'b0;
`ifdef CB_ZZ_DOUBLE_BUF_EN
      buf1_q        <= {704{1'b0}};
      buf1_full_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      buf0_q        <= buf0_d;
      coef_out_q    <= coef_out_d;
      coef_index_q  <= coef_index_d;
      coef_valid_q  <= coef_valid_d;
      coef_last_q   <= coef_last_d;
      block_ready_q <= block_ready_d;
      drop_q        <= drop_d;
`ifdef CB_ZZ_DOUBLE_BUF_EN
      buf1_q        <= buf1_d;
      buf1_full_q   <= buf1_full_d;
`endif
    end
  end

  assign block_ready = block_ready_q;
  assign coef_out    = coef_out_q;
  assign coef_index  = coef_index_q;
  assign coef_valid  = coef_valid_q;
  assign coef_last   = coef_last_q;
  assign drop        = drop_q;

endmodule
